mem_dumper: RTL and testbench

MEM_DUMPER -- requirements
Module: mem_dumper

---
 rtl/prog_pkg.sv | 16 +
 rtl/mem_dumper_if.sv | 28 ++
 rtl/mem_dumper.sv | 130 +++++++++++++
 tb/tb_mem_dumper.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/prog_pkg.sv
// Shared definitions for the programmer/dumper blocks: FSM state encoding and
// the default memory size.
package prog_pkg;

    localparam int MEM_SIZE_DEF = 32767;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        WT   = 3'd2,
        PUSH = 3'd3,
        CSUM = 3'd4,
        DONE = 3'd5
    } dump_state_t;

endpackage

// File: rtl/mem_dumper_if.sv
// Control, memory-read and TX-FIFO signals of the memory dumper.
// The master modport is the dumper itself; the slave modport is its environment.
interface mem_dumper_if;

    logic        dumpEn;
    logic [31:0] dumpLen;
    logic        busy;
    logic        done;

    logic        memRdEn;
    logic [31:0] memAddr;
    logic [7:0]  memData;

    logic        txFfFull;
    logic        txWrEn;
    logic [7:0]  txData;

    modport master (
        input  dumpEn, dumpLen, memData, txFfFull,
        output busy, done, memRdEn, memAddr, txWrEn, txData
    );

    modport slave (
        output dumpEn, dumpLen, memData, txFfFull,
        input  busy, done, memRdEn, memAddr, txWrEn, txData
    );

endinterface

// File: rtl/mem_dumper.sv
// Streams min(dumpLen, MEM_SIZE) memory bytes into a TX FIFO, then a
// two's-complement checksum byte so that all emitted bytes sum to 0 mod 256.
import prog_pkg::*;

module mem_dumper #(
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mem_dumper_if.master bus
);

    localparam logic [31:0] MEM_SIZE_W = 32'(MEM_SIZE);

    dump_state_t state, state_nx;

    logic [31:0] addr;
    logic [31:0] len;
    logic [7:0]  sum;
    logic [7:0]  hold;
    logic        en_low;

    logic        start;
    logic        rd_en;
    logic        wr_en;
    logic [7:0]  wr_data;

    function automatic logic [31:0] clamp_len(input logic [31:0] req);
        return (req > MEM_SIZE_W) ? MEM_SIZE_W : req;
    endfunction

    function automatic logic [7:0] csum_byte(input logic [7:0] acc);
        return 8'(8'd0 - acc);
    endfunction

    // en_low resets to 0, so a dumpEn already high at reset release must
    // first be seen low before a start can be recognised.
    assign start = bus.dumpEn && en_low;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: if (start) state_nx = (bus.dumpLen == 32'd0) ? CSUM : RD;
            RD:   state_nx = bus.dumpEn ? WT : IDLE;
            WT:   state_nx = bus.dumpEn ? PUSH : IDLE;
            PUSH: begin
                if (!bus.dumpEn)
                    state_nx = IDLE;
                else if (!bus.txFfFull)
                    state_nx = (addr + 32'd1 == len) ? CSUM : RD;
            end
            CSUM: begin
                if (!bus.dumpEn)
                    state_nx = IDLE;
                else if (!bus.txFfFull)
                    state_nx = DONE;
            end
            DONE:    if (!bus.dumpEn) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Strobes are qualified by dumpEn so an abort silences them in the same cycle.
    always_comb begin
        rd_en   = 1'b0;
        wr_en   = 1'b0;
        wr_data = 8'd0;
        case (state)
            RD: rd_en = bus.dumpEn;
            PUSH: begin
                if (bus.dumpEn && !bus.txFfFull) begin
                    wr_en   = 1'b1;
                    wr_data = hold;
                end
            end
            CSUM: begin
                if (bus.dumpEn && !bus.txFfFull) begin
                    wr_en   = 1'b1;
                    wr_data = csum_byte(sum);
                end
            end
            default: ;
        endcase
    end

    assign bus.memRdEn = rd_en;
    assign bus.memAddr = rd_en ? addr : 32'd0;
    assign bus.txWrEn  = wr_en;
    assign bus.txData  = wr_data;
    assign bus.busy    = (state == RD) || (state == WT) || (state == PUSH) || (state == CSUM);
    assign bus.done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr   <= 32'd0;
            len    <= 32'd0;
            sum    <= 8'd0;
            hold   <= 8'd0;
            en_low <= 1'b0;
        end else begin
            en_low <= !bus.dumpEn;
            case (state)
                IDLE: begin
                    if (start) begin
                        len  <= clamp_len(bus.dumpLen);
                        addr <= 32'd0;
                        sum  <= 8'd0;
                    end
                end
                WT: hold <= bus.memData;
                PUSH: begin
                    if (wr_en) begin
                        sum  <= sum + hold;
                        addr <= addr + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_dumper.sv
// Self-checking bench for mem_dumper: table-driven dumps against a byte-list
// reference model, plus hand-written stall, abort and reset sequences.
module tb_mem_dumper;

    localparam int MEM_SZ = 64;

    typedef struct {
        int unsigned len;
        bit          rnd_full;
        int          exp_writes;
        int          exp_reads;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    mem_dumper_if bus ();

    mem_dumper #(.MEM_SIZE(MEM_SZ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [MEM_SZ];
    logic [7:0]  wq[$];
    int          wc[$];
    logic [7:0]  exp_q[$];
    int          cyc = 0;
    int          nrd = 0;
    int          last_addr = -1;
    int          viol = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous memory: data is valid the cycle after the read strobe.
    always @(posedge clk) begin
        if (bus.memRdEn) bus.memData <= mem[bus.memAddr % MEM_SZ];
    end

    always @(negedge clk) begin
        if (bus.txWrEn) begin
            wq.push_back(bus.txData);
            wc.push_back(cyc);
        end
        if (bus.memRdEn) begin
            nrd++;
            last_addr = int'(bus.memAddr);
            if (bus.memAddr >= MEM_SZ) viol++;
        end
        if (bus.memRdEn && bus.txWrEn) viol++;
        if (!bus.memRdEn && bus.memAddr != 32'd0) viol++;
        if (!bus.txWrEn && bus.txData != 8'd0) viol++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Expected FIFO stream: the first min(len, MEM_SZ) memory bytes, then
    // whatever byte brings the total to zero modulo 256.
    task automatic build_exp(input int unsigned len);
        int unsigned n;
        int          total;
        n = (len > MEM_SZ) ? MEM_SZ : len;
        total = 0;
        exp_q.delete();
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(mem[i]);
            total += int'(mem[i]);
        end
        exp_q.push_back(8'((256 - (total % 256)) % 256));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        wq.delete();
        wc.delete();
        nrd = 0;
        last_addr = -1;
    endtask

    task automatic compare_stream(input string name);
        int errs;
        errs = 0;
        check({name, "_count"}, wq.size(), exp_q.size());
        foreach (exp_q[i]) begin
            if (i >= wq.size() || wq[i] !== exp_q[i]) errs++;
        end
        check({name, "_bytes"}, errs, 0);
    endtask

    task automatic wait_done(input string name);
        int t;
        t = 0;
        while (!bus.done && t < 4000) begin
            tick();
            t++;
        end
        check({name, "_done_timeout"}, (t < 4000), 1);
    endtask

    task automatic wait_rd(input string name);
        int t;
        t = 0;
        while (!bus.memRdEn && t < 20) begin
            tick();
            t++;
        end
        check({name, "_rd_seen"}, bus.memRdEn, 1);
    endtask

    task automatic run_vec(input string name, input vec_t v);
        int gaps;
        bus.dumpEn   = 1'b0;
        bus.txFfFull = 1'b0;
        tick();
        clear_log();
        bus.dumpLen = v.len;
        bus.dumpEn  = 1'b1;
        tick();
        bus.dumpLen = $urandom;
        begin
            int t;
            t = 0;
            while (!bus.done && t < 4000) begin
                if (v.rnd_full) bus.txFfFull = ($urandom_range(0, 2) == 0);
                tick();
                t++;
            end
            check({name, "_done_timeout"}, (t < 4000), 1);
        end
        bus.txFfFull = 1'b0;
        repeat (3) tick();
        build_exp(v.len);
        check({name, "_writes"}, wq.size(), v.exp_writes);
        check({name, "_reads"}, nrd, v.exp_reads);
        compare_stream(name);
        if (v.exp_reads > 0) check({name, "_last_addr"}, last_addr, v.exp_reads - 1);
        if (!v.rnd_full && wc.size() == v.exp_writes && v.exp_writes > 1) begin
            gaps = 0;
            for (int i = 1; i < v.exp_writes - 1; i++)
                if (wc[i] - wc[i-1] != 3) gaps++;
            if (wc[v.exp_writes-1] - wc[v.exp_writes-2] != 1) gaps++;
            check({name, "_spacing"}, gaps, 0);
        end
        bus.dumpEn = 1'b0;
        tick();
        check({name, "_idle_after"}, {bus.busy, bus.done}, 2'b00);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{len: 3,     rnd_full: 1'b0, exp_writes: 4,  exp_reads: 3};
        vecs[1] = '{len: 0,     rnd_full: 1'b0, exp_writes: 1,  exp_reads: 0};
        vecs[2] = '{len: 1,     rnd_full: 1'b0, exp_writes: 2,  exp_reads: 1};
        vecs[3] = '{len: 64,    rnd_full: 1'b0, exp_writes: 65, exp_reads: 64};
        vecs[4] = '{len: 65,    rnd_full: 1'b0, exp_writes: 65, exp_reads: 64};
        vecs[5] = '{len: 40000, rnd_full: 1'b0, exp_writes: 65, exp_reads: 64};
        vecs[6] = '{len: 7,     rnd_full: 1'b1, exp_writes: 8,  exp_reads: 7};
        vecs[7] = '{len: 20,    rnd_full: 1'b1, exp_writes: 21, exp_reads: 20};

        for (int i = 0; i < MEM_SZ; i++) mem[i] = 8'($urandom);
        mem[0] = 8'h11;
        mem[1] = 8'h22;
        mem[2] = 8'h33;

        bus.dumpEn   = 1'b0;
        bus.dumpLen  = 32'd0;
        bus.txFfFull = 1'b0;
        repeat (3) tick();
        check("rst_busy",  bus.busy, 0);
        check("rst_done",  bus.done, 0);
        check("rst_rden",  bus.memRdEn, 0);
        check("rst_addr",  bus.memAddr, 0);
        check("rst_wren",  bus.txWrEn, 0);
        check("rst_txdat", bus.txData, 0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 8; i++) begin
            run_vec($sformatf("vec%0d", i), vecs[i]);
            if (i == 0) check("csum_fixed", (wq.size() == 4) ? 32'(wq[3]) : 32'hDEAD, 32'h9A);
        end

        // Stall: FIFO full throughout the first PUSH of a 2-byte dump.
        begin
            int stall_bad;
            stall_bad = 0;
            clear_log();
            bus.dumpLen = 32'd2;
            bus.dumpEn  = 1'b1;
            wait_rd("stall");
            tick();
            bus.txFfFull = 1'b1;
            repeat (5) begin
                tick();
                if (bus.txWrEn || !bus.busy) stall_bad++;
            end
            bus.txFfFull = 1'b0;
            wait_done("stall");
            repeat (2) tick();
            check("stall_no_write", stall_bad, 0);
            build_exp(2);
            compare_stream("stall");
            bus.dumpEn = 1'b0;
            tick();
        end

        // Abort: drop dumpEn while waiting for the second byte.
        begin
            clear_log();
            bus.dumpLen = 32'd5;
            bus.dumpEn  = 1'b1;
            wait_rd("abort1");
            tick();
            tick();
            wait_rd("abort2");
            tick();
            bus.dumpEn = 1'b0;
            #1;
            check("abort_strobes", {bus.memRdEn, bus.txWrEn}, 2'b00);
            tick();
            check("abort_idle", {bus.busy, bus.done}, 2'b00);
            repeat (4) tick();
            check("abort_writes", wq.size(), 1);
            check("abort_byte0", (wq.size() > 0) ? 32'(wq[0]) : 32'hDEAD, 32'(mem[0]));
        end

        // Reset mid-PUSH, then reset release with dumpEn still high.
        begin
            int rd_snap;
            clear_log();
            bus.dumpLen = 32'd3;
            bus.dumpEn  = 1'b1;
            wait_rd("rstpush");
            tick();
            tick();
            check("rstpush_pre_wr", bus.txWrEn, 1);
            #1;
            rst = 1'b1;
            #1;
            check("rstpush_async", {bus.memRdEn, bus.txWrEn, bus.txData, bus.busy, bus.done}, 12'd0);
            wq.delete();
            rd_snap = nrd;
            repeat (3) tick();
            rst = 1'b0;
            repeat (10) tick();
            check("rel_no_reads", nrd, rd_snap);
            check("rel_no_writes", wq.size(), 0);
            check("rel_not_busy", bus.busy, 0);
            run_vec("after_rst", vecs[0]);
        end

        check("invariants", viol, 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
